lsu: RTL



---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_if.sv | 32 +++
 rtl/lsu_align.sv | 39 +++
 rtl/lsu.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM encoding
// and small decode helpers used by both the control path and the aligner.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_e;

  // Right-justified byte-lane mask for an access of the given width code.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_mask = 4'b0001;
      F3_H, F3_HU: size_mask = 4'b0011;
      F3_W:        size_mask = 4'b1111;
      default:     size_mask = 4'b0000;
    endcase
  endfunction

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
    end
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request/response handshake plus the 4-lane data memory port.
// The slave view belongs to the LSU; the master view is the surrounding system.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  logic [ADDR_W-1:0]     daddr;
  logic [DATA_W-1:0]     dwdata;
  logic [DATA_W/8-1:0]   dwe;
  logic [DATA_W-1:0]     drdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, drdata,
    output req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, dwe
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, drdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, dwe
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store lane mask / data image across two words,
// and load extraction with sign or zero extension from the {hi,lo} pair.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  lane_mask_o,
  output logic [63:0] store_img_o,
  output logic        split_o,
  output logic [31:0] load_o
);

  logic [5:0]  bit_off;
  logic [31:0] win;

  assign bit_off     = {1'b0, off_i, 3'b000};
  assign lane_mask_o = {4'b0000, size_mask(funct3_i)} << off_i;
  assign store_img_o = {32'h0, wdata_i} << bit_off;
  // Any lane landing in the upper word means a second memory access.
  assign split_o     = |lane_mask_o[7:4];
  assign win         = 32'({hi_i, lo_i} >> bit_off);

  always_comb begin
    load_o = '0;
    case (funct3_i)
      F3_B:    load_o = {{24{win[7]}}, win[7:0]};
      F3_H:    load_o = {{16{win[15]}}, win[15:0]};
      F3_W:    load_o = win;
      F3_BU:   load_o = {24'h0, win[7:0]};
      F3_HU:   load_o = {16'h0, win[15:0]};
      default: load_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, performs one or two word
// accesses on the data port, then pulses a single-cycle response.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // fixed at 32: four byte lanes
) (
  input logic clk,
  input logic reset,
  lsu_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;

  logic [7:0]        lane_mask;
  logic [63:0]       store_img;
  logic              split;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] word_addr;
  logic [3:0]        lane_sel;
  logic [3:0]        dwe_lane;
  logic              legal;

  lsu_align u_align (
    .off_i       (addr_q[1:0]),
    .funct3_i    (funct3_q),
    .wdata_i     (wdata_q),
    .lo_i        (lo_q),
    .hi_i        (hi_q),
    .lane_mask_o (lane_mask),
    .store_img_o (store_img),
    .split_o     (split),
    .load_o      (load_data)
  );

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign legal     = is_legal(bus.req_we, bus.req_funct3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          funct3_d = bus.req_funct3;
          we_d     = bus.req_we;
          wdata_d  = bus.req_wdata;
          err_d    = ~legal;
          // Clearing hi here makes a non-split load see zeros above lo.
          lo_d     = '0;
          hi_d     = '0;
          state_d  = legal ? ACC1 : RESP;
        end
      end
      ACC1: begin
        lo_d    = bus.drdata;
        state_d = split ? ACC2 : RESP;
      end
      ACC2: begin
        hi_d    = bus.drdata;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.daddr      = '0;
    bus.dwdata     = '0;
    lane_sel       = 4'b0000;
    case (state_q)
      IDLE: bus.req_ready = 1'b1;
      ACC1: begin
        bus.daddr  = word_addr;
        bus.dwdata = store_img[31:0];
        lane_sel   = lane_mask[3:0];
      end
      ACC2: begin
        bus.daddr  = word_addr + ADDR_W'(4);
        bus.dwdata = store_img[63:32];
        lane_sel   = lane_mask[7:4];
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = (we_q || err_q) ? '0 : load_data;
      end
      default: ;
    endcase
  end

  // Write enables are masked by reset so an interrupted access cannot land.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign dwe_lane[gi] = we_q & lane_sel[gi] & ~reset;
  end
  assign bus.dwe = dwe_lane;

endmodule
